vga_write_arbiter: RTL and testbench

Shares the single VGA adapter pixel-write port between the draw engines: screen drawer, coin drawer, car drawer and car eraser. Grants are round-robin and locked until the granted engine signals its last pixel. The block registers the granted engine's pixel onto the adapter port and revokes stalled grants with a watchdog. It sits between the draw engines and the VGA adapter, beneath the animation-control FSM.

---
 rtl/vga_write_arbiter_pkg.sv | 25 ++
 rtl/vga_write_arbiter_rr_pick.sv | 32 +++
 rtl/vga_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_write_arbiter_pkg.sv
// Shared constants for the VGA write path: screen geometry, arbiter state
// encoding and draw-engine indices.
package vga_write_arbiter_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam int ENG_SCREEN = 0;
  localparam int ENG_COIN   = 1;
  localparam int ENG_CAR    = 2;
  localparam int ENG_ERASE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping, reported both one-hot and as a binary index.
module rr_pick
  import vga_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int cand;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel port between draw engines,
// with lock-until-last grants, a one-cycle gap between grants and a watchdog.
module vga_write_arbiter
  import vga_write_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int X_W     = vga_write_arbiter_pkg::X_W,
  parameter int Y_W     = vga_write_arbiter_pkg::Y_W,
  parameter int C_W     = vga_write_arbiter_pkg::C_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         plot_in,
  input  logic [N-1:0]         last_in,
  input  logic [N*X_W-1:0]     x_in,
  input  logic [N*Y_W-1:0]     y_in,
  input  logic [N*C_W-1:0]     colour_in,
  output logic [N-1:0]         gnt,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     pix_count
);

  localparam int PW   = idx_w(N);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  arb_state_e     state_reg, state_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic [PW-1:0]  idx_reg, idx_next;
  logic [PW-1:0]  ptr_reg, ptr_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [X_W-1:0] vga_x_reg, vga_x_next;
  logic [Y_W-1:0] vga_y_reg, vga_y_next;
  logic [C_W-1:0] vga_c_reg, vga_c_next;
  logic           vga_plot_reg, vga_plot_next;
  logic           busy_reg, busy_next;
  logic           terr_reg, terr_next;

  logic [N-1:0]   pick_onehot;
  logic [PW-1:0]  pick_idx;
  logic           pick_any;

  logic [X_W-1:0] x_arr [N];
  logic [Y_W-1:0] y_arr [N];
  logic [C_W-1:0] c_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign x_arr[gi] = x_in[gi*X_W +: X_W];
      assign y_arr[gi] = y_in[gi*Y_W +: Y_W];
      assign c_arr[gi] = colour_in[gi*C_W +: C_W];
    end
  endgenerate

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req        (req),
    .ptr        (ptr_reg),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  logic g_req, g_plot, g_last;
  logic rel_last, rel_drop, rel_to, release_now;

  assign g_req       = req[idx_reg];
  assign g_plot      = plot_in[idx_reg];
  assign g_last      = last_in[idx_reg];
  assign rel_last    = g_plot & g_last;
  assign rel_drop    = ~g_req;
  // Watchdog only fires on a cycle with no pixel; any plot restarts it.
  assign rel_to      = (wd_reg == WD_W'(TIMEOUT - 1)) & ~g_plot;
  assign release_now = rel_last | rel_drop | rel_to;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pick_any) state_next = ST_GRANT;
      ST_GRANT: if (release_now) state_next = ST_GAP;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_next      = gnt_reg;
    idx_next      = idx_reg;
    ptr_next      = ptr_reg;
    wd_next       = wd_reg;
    cnt_next      = cnt_reg;
    vga_x_next    = vga_x_reg;
    vga_y_next    = vga_y_reg;
    vga_c_next    = vga_c_reg;
    vga_plot_next = 1'b0;
    terr_next     = 1'b0;
    busy_next     = (state_next == ST_GRANT);
    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_next = pick_onehot;
          idx_next = pick_idx;
          wd_next  = '0;
          cnt_next = '0;
        end
      end
      ST_GRANT: begin
        vga_x_next    = x_arr[idx_reg];
        vga_y_next    = y_arr[idx_reg];
        vga_c_next    = c_arr[idx_reg];
        vga_plot_next = g_plot;
        if (g_plot && (cnt_reg != '1)) cnt_next = cnt_reg + CNT_W'(1);
        wd_next = g_plot ? '0 : wd_reg + WD_W'(1);
        if (release_now) begin
          gnt_next  = '0;
          ptr_next  = (idx_reg == PW'(N - 1)) ? '0 : idx_reg + PW'(1);
          terr_next = rel_to;
        end
      end
      default: gnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_reg      <= '0;
      idx_reg      <= '0;
      ptr_reg      <= '0;
      wd_reg       <= '0;
      cnt_reg      <= '0;
      vga_x_reg    <= '0;
      vga_y_reg    <= '0;
      vga_c_reg    <= '0;
      vga_plot_reg <= 1'b0;
      busy_reg     <= 1'b0;
      terr_reg     <= 1'b0;
    end else begin
      gnt_reg      <= gnt_next;
      idx_reg      <= idx_next;
      ptr_reg      <= ptr_next;
      wd_reg       <= wd_next;
      cnt_reg      <= cnt_next;
      vga_x_reg    <= vga_x_next;
      vga_y_reg    <= vga_y_next;
      vga_c_reg    <= vga_c_next;
      vga_plot_reg <= vga_plot_next;
      busy_reg     <= busy_next;
      terr_reg     <= terr_next;
    end
  end

  assign gnt         = gnt_reg;
  assign vga_x       = vga_x_reg;
  assign vga_y       = vga_y_reg;
  assign vga_colour  = vga_c_reg;
  assign vga_plot    = vga_plot_reg;
  assign busy        = busy_reg;
  assign timeout_err = terr_reg;
  assign pix_count   = cnt_reg;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter; a negedge monitor checks forwarded
// pixels and grant order against queues filled by the stimulus.
module tb_vga_write_arbiter;

  localparam int N = 4, X_W = 8, Y_W = 7, C_W = 3, TIMEOUT = 16, CNT_W = 15;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [N-1:0] req = '0, plot_in = '0, last_in = '0;
  logic [N*X_W-1:0] x_in = '0;
  logic [N*Y_W-1:0] y_in = '0;
  logic [N*C_W-1:0] colour_in = '0;
  logic [N-1:0] gnt;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic vga_plot, busy, timeout_err;
  logic [CNT_W-1:0] pix_count;

  vga_write_arbiter #(
    .N(N), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .plot_in(plot_in), .last_in(last_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .timeout_err(timeout_err), .pix_count(pix_count)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int plot_seen = 0, terr_seen = 0;
  pix_t exp_pix[$];
  logic [N-1:0] exp_gnt[$];
  int gnt_rise_cyc[$];
  logic [N-1:0] prev_gnt = '0;
  pix_t mon_pix;
  logic [N-1:0] mon_gnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected pixel per vga_plot and one grant per rising gnt.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_gnt = '0;
    end else begin
      if (vga_plot) begin
        plot_seen++;
        if (exp_pix.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d with empty queue", vga_x, vga_y, vga_colour);
        end else begin
          mon_pix = exp_pix.pop_front();
          check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(mon_pix));
        end
      end
      if (gnt != '0 && prev_gnt == '0) begin
        gnt_rise_cyc.push_back(cyc);
        if (exp_gnt.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_grant: got %b with empty queue", gnt);
        end else begin
          mon_gnt = exp_gnt.pop_front();
          check("grant_order", 32'(gnt), 32'(mon_gnt));
        end
      end
      if (timeout_err) terr_seen++;
      prev_gnt = gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int e, input logic p, input logic l,
                       input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    plot_in[e] = p;
    last_in[e] = l;
    x_in[e*X_W +: X_W] = x;
    y_in[e*Y_W +: Y_W] = y;
    colour_in[e*C_W +: C_W] = c;
  endtask

  task automatic send(input int e, input logic l,
                      input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    drive(e, 1'b1, l, x, y, c);
    exp_pix.push_back(pix_t'({x, y, c}));
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    if (gnt == '0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: grant timeout, got gnt=%b expected a grant within 20 cycles", name, gnt);
    end
  endtask

  function automatic int gidx(input logic [N-1:0] g);
    int r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, r0, t0, n, e;
    logic [3:0] pat2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_plot", 32'(vga_plot), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_terr", 32'(timeout_err), 32'(0));
    check("rst_cnt", 32'(pix_count), 32'(0));
    check("rst_x", 32'(vga_x), 32'(0));
    resetn = 1'b1;
    tick();

    // T1: engine 0 streams five pixels, last on the fifth
    req = 4'b0001;
    exp_gnt.push_back(4'b0001);
    p0 = plot_seen;
    tick();
    check("t1_gnt_latency", 32'(gnt), 32'(4'b0001));
    check("t1_busy", 32'(busy), 32'(1));
    for (int k = 0; k < 5; k++) begin
      send(0, k == 4, 8'(10 + k), 7'(20 + k), 3'(k));
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    req = '0;
    check("t1_gnt_fall", 32'(gnt), 32'(0));
    check("t1_busy_fall", 32'(busy), 32'(0));
    check("t1_pix_count", 32'(pix_count), 32'(5));
    tick();
    tick();
    check("t1_plot_cycles", 32'(plot_seen - p0), 32'(5));

    // T2: all request, one pixel each; order 0,1,2,3,0 every 3 cycles
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    r0 = gnt_rise_cyc.size();
    exp_gnt.push_back(4'b0001);
    exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b0100);
    exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("t2_wait");
      e = gidx(gnt);
      send(e, 1'b1, 8'(60 + g), 7'(70 + g), 3'(g));
      tick();
      drive(e, 1'b0, 1'b0, '0, '0, '0);
    end
    req = '0;
    tick();
    tick();
    if (gnt_rise_cyc.size() >= r0 + 5) begin
      for (int i = 1; i < 5; i++)
        check("t2_spacing", 32'(gnt_rise_cyc[r0+i] - gnt_rise_cyc[r0+i-1]), 32'(3));
    end else begin
      n_checks++; n_fail++;
      $display("FAIL t2_grant_count: got %0d rises expected 5", gnt_rise_cyc.size() - r0);
    end

    // T3: engine 2 granted while others toggle plot/last (ptr is 1)
    req = 4'b0100;
    exp_gnt.push_back(4'b0100);
    wait_gnt("t3_wait");
    pat2 = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      drive(0, k % 2 == 0, k % 2 == 0, 8'(100), 7'(50), 3'(1));
      drive(1, k % 2 == 0, k % 2 == 0, 8'(101), 7'(51), 3'(2));
      drive(3, k % 2 == 0, k % 2 == 0, 8'(103), 7'(53), 3'(3));
      if (pat2[k]) send(2, k == 3, 8'(30 + k), 7'(40 + k), 3'(4 + k));
      else         drive(2, 1'b0, 1'b0, 8'(99), 7'(99), 3'(7));
      tick();
    end
    plot_in = '0;
    last_in = '0;
    req = '0;
    check("t3_gnt_fall", 32'(gnt), 32'(0));
    check("t3_pix_count", 32'(pix_count), 32'(3));
    tick();
    tick();

    // T4: engine 1 granted then silent; watchdog revoke (ptr is 3)
    req = 4'b0010;
    exp_gnt.push_back(4'b0010);
    t0 = terr_seen;
    wait_gnt("t4_wait");
    n = 0;
    while (gnt != '0 && n < 40) begin
      n++;
      tick();
    end
    check("t4_grant_cycles", 32'(n), 32'(TIMEOUT));
    check("t4_terr_pulse", 32'(timeout_err), 32'(1));
    check("t4_pix_count", 32'(pix_count), 32'(0));
    tick();
    req = '0;
    check("t4_terr_clear", 32'(timeout_err), 32'(0));
    tick();
    tick();
    check("t4_terr_once", 32'(terr_seen - t0), 32'(1));
    // ptr must now be 2: from 2 picks 2; from 3/0 picks 0; from 1 picks 1
    req = 4'b0111;
    exp_gnt.push_back(4'b0100);
    wait_gnt("t4_ptr_wait");
    check("t4_ptr_is_2", 32'(gnt), 32'(4'b0100));
    req = '0;
    tick();
    check("t4_drop_release", 32'(gnt), 32'(0));
    tick();
    tick();

    // T5: asynchronous reset mid-grant while plotting
    req = 4'b0001;
    exp_gnt.push_back(4'b0001);
    wait_gnt("t5_wait");
    send(0, 1'b0, 8'(5), 7'(6), 3'(7));
    tick();
    send(0, 1'b0, 8'(8), 7'(9), 3'(1));
    check("t5_plot_before_rst", 32'(vga_plot), 32'(1));
    #3;
    resetn = 1'b0;
    #1;
    check("t5_async_gnt", 32'(gnt), 32'(0));
    check("t5_async_plot", 32'(vga_plot), 32'(0));
    check("t5_async_busy", 32'(busy), 32'(0));
    exp_pix.delete();
    req = '0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    resetn = 1'b1;
    tick();
    req = 4'b1000;
    exp_gnt.push_back(4'b1000);
    wait_gnt("t5_wait3");
    check("t5_gnt3", 32'(gnt), 32'(4'b1000));
    send(3, 1'b1, 8'(159), 7'(119), 3'(5));
    tick();
    drive(3, 1'b0, 1'b0, '0, '0, '0);
    req = '0;
    tick();
    tick();

    // T6: granted engine drops req together with a non-last pixel (ptr is 0)
    req = 4'b0001;
    exp_gnt.push_back(4'b0001);
    wait_gnt("t6_wait");
    send(0, 1'b0, 8'(1), 7'(2), 3'(3));
    tick();
    check("t6_still_granted", 32'(gnt), 32'(4'b0001));
    send(0, 1'b0, 8'(4), 7'(5), 3'(6));
    req = '0;
    tick();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    check("t6_gnt_fall", 32'(gnt), 32'(0));
    check("t6_pix_count", 32'(pix_count), 32'(2));
    repeat (4) tick();
    check("t6_count_hold", 32'(pix_count), 32'(2));
    check("t6_busy_idle", 32'(busy), 32'(0));

    check("pix_queue_drained", 32'(exp_pix.size()), 32'(0));
    check("gnt_queue_drained", 32'(exp_gnt.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
